// File: rtl/nand_share_pkg.sv
// Shared types, default sizes and the round-robin pick helper for the NAND share arbiter.
package nand_share_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    // The helper works on a padded request vector so one function serves any N_REQ up to MAX_REQ.
    localparam int MAX_REQ = 32;
    localparam int IDX_W   = 5;

    // First valid index after 'last', wrapping modulo n; returns 0 when nothing is valid.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [IDX_W-1:0]   last,
        input int                 n
    );
        logic [IDX_W-1:0] idx;
        logic             found;
        rr_pick = {IDX_W{1'b0}};
        found   = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = IDX_W'((int'(last) + k) % n);
            if ((k <= n) && !found && valid[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end else begin
                found   = found;
            end
        end
    endfunction

endpackage

// File: rtl/nand_share_arbiter_rr_arbiter.sv
// Combinational round-robin winner selection plus the last-grant pointer.
module rr_arbiter
    import nand_share_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] i_valid,
    input  logic             i_enable,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_win_id,
    output logic             o_fire
);

    logic [ID_W-1:0]    r_last_grant;
    logic [MAX_REQ-1:0] w_valid_pad;
    logic [ID_W-1:0]    w_win_id;
    logic               w_fire;

    assign w_fire   = i_enable & (|i_valid);
    assign o_fire   = w_fire;
    assign o_win_id = w_win_id;

    // Winner index and the one-hot grant derived from it.
    always_comb begin
        w_valid_pad                = {MAX_REQ{1'b0}};
        w_valid_pad[N_REQ-1:0]     = i_valid;
        w_win_id                   = ID_W'(rr_pick(w_valid_pad, IDX_W'(r_last_grant), N_REQ));
        o_grant                    = {N_REQ{1'b0}};
        if (w_fire) begin
            o_grant[w_win_id] = 1'b1;
        end else begin
            o_grant = {N_REQ{1'b0}};
        end
    end

    // Pointer starts at the top index so requester 0 wins the first arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= ID_W'(N_REQ - 1);
        end else if (w_fire) begin
            r_last_grant <= w_win_id;
        end
    end

endmodule

// File: rtl/nand_share_arbiter.sv
// One registered bitwise NAND shared by N_REQ requesters: grant, execute, then hold the
// result until the consumer takes it.
module nand_share_arbiter
    import nand_share_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WIDTH-1:0]     req_a,
    input  logic [N_REQ*WIDTH-1:0]     req_b,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       res_valid,
    output logic [WIDTH-1:0]           res_data,
    output logic [$clog2(N_REQ)-1:0]   res_id,
    input  logic                       res_ready,
    output logic                       busy,
    output logic [CNT_W-1:0]           op_count
);

    localparam int ID_W = $clog2(N_REQ);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [N_REQ-1:0]   w_grant;
    logic [ID_W-1:0]    w_win_id;
    logic               w_fire;
    logic               w_grant_en;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic [WIDTH-1:0]   r_op_a;
    logic [WIDTH-1:0]   r_op_b;
    logic [ID_W-1:0]    r_op_id;
    logic               r_res_valid;
    logic [WIDTH-1:0]   r_res_data;
    logic [ID_W-1:0]    r_res_id;
    logic [CNT_W-1:0]   r_op_count;

    // Grants only from IDLE, and never while reset is held so req_ready reads 0 in reset.
    assign w_grant_en = (r_state == ST_IDLE) & ena & rst_n;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arbiter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (req_valid),
        .i_enable (w_grant_en),
        .o_grant  (w_grant),
        .o_win_id (w_win_id),
        .o_fire   (w_fire)
    );

    // Operand select; the grant is one-hot so an AND-OR mux is sufficient.
    always_comb begin
        w_sel_a = {WIDTH{1'b0}};
        w_sel_b = {WIDTH{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            w_sel_a = w_sel_a | ({WIDTH{w_grant[i]}} & req_a[i*WIDTH +: WIDTH]);
            w_sel_b = w_sel_b | ({WIDTH{w_grant[i]}} & req_b[i*WIDTH +: WIDTH]);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_fire) begin
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: w_state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (res_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, NAND result register and saturating completion counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a      <= {WIDTH{1'b0}};
            r_op_b      <= {WIDTH{1'b0}};
            r_op_id     <= {ID_W{1'b0}};
            r_res_valid <= 1'b0;
            r_res_data  <= {WIDTH{1'b0}};
            r_res_id    <= {ID_W{1'b0}};
            r_op_count  <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fire) begin
                        r_op_a  <= w_sel_a;
                        r_op_b  <= w_sel_b;
                        r_op_id <= w_win_id;
                    end
                end
                ST_EXEC: begin
                    r_res_data  <= ~(r_op_a & r_op_b);
                    r_res_id    <= r_op_id;
                    r_res_valid <= 1'b1;
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        if (r_op_count != {CNT_W{1'b1}}) begin
                            r_op_count <= r_op_count + CNT_W'(1);
                        end
                    end
                end
                default: r_res_valid <= 1'b0;
            endcase
        end
    end

    assign req_ready = w_grant;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;
    assign busy      = (r_state != ST_IDLE);
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_nand_share_arbiter.sv
// Self-checking bench: directed sequences, a vector table and random traffic against a
// transaction-level model (in-flight queue with grant timestamps).
module tb_nand_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic [7:0]  res_data;
    logic [1:0]  res_id;
    logic        res_ready;
    logic        busy;
    logic [15:0] op_count;

    logic        rst2_n;
    logic [3:0]  req_ready2;
    logic        res_valid2;
    logic [7:0]  res_data2;
    logic [1:0]  res_id2;
    logic        busy2;
    logic [3:0]  op_count2;
    int          n2 = 0;

    always #5 clk = ~clk;

    nand_share_arbiter dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .req_valid(req_valid), .req_a(req_a),
        .req_b(req_b), .req_ready(req_ready), .res_valid(res_valid), .res_data(res_data),
        .res_id(res_id), .res_ready(res_ready), .busy(busy), .op_count(op_count)
    );

    nand_share_arbiter #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst2_n), .ena(1'b1), .req_valid(4'b0001), .req_a(32'h1234_5678),
        .req_b(32'h9ABC_DEF0), .req_ready(req_ready2), .res_valid(res_valid2),
        .res_data(res_data2), .res_id(res_id2), .res_ready(1'b1), .busy(busy2),
        .op_count(op_count2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] d;
        int         id;
        int         t;
    } op_t;

    op_t        m_q[$];
    int         m_last  = 3;
    int         m_count = 0;
    int         m_cyc   = 0;
    int         m_win;
    logic [3:0] m_ready;
    logic       m_rv;

    function automatic int pick(input logic [3:0] v, input int last);
        for (int off = 1; off <= 4; off++) begin
            int idx = (last + off) % 4;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_expect();
        m_ready = 4'b0000;
        m_win   = -1;
        if (m_q.size() == 0 && ena && (req_valid != 4'b0000)) begin
            m_win = pick(req_valid, m_last);
            m_ready[m_win] = 1'b1;
        end
        m_rv = (m_q.size() > 0) && (m_cyc >= m_q[0].t + 2);
    endtask

    task automatic model_update();
        if (m_win >= 0) begin
            op_t o;
            o.d  = ~(req_a[m_win*8 +: 8] & req_b[m_win*8 +: 8]);
            o.id = m_win;
            o.t  = m_cyc;
            m_q.push_back(o);
            m_last = m_win;
        end else if (m_rv && res_ready) begin
            m_q.delete(0);
            if (m_count < 65535) m_count++;
        end
        m_cyc++;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_last  = 3;
        m_count = 0;
    endtask

    // Sampled outputs of the latest step, for the directed checks.
    logic [3:0]  s_ready;
    logic        s_rv;
    logic [7:0]  s_data;
    logic [1:0]  s_id;
    logic [15:0] s_cnt;

    task automatic step(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                        input logic e, input logic rr);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        ena       = e;
        res_ready = rr;
        @(negedge clk);
        model_expect();
        s_ready = req_ready;
        s_rv    = res_valid;
        s_data  = res_data;
        s_id    = res_id;
        s_cnt   = op_count;
        chk("req_ready", {28'd0, req_ready}, {28'd0, m_ready});
        chk("res_valid", {31'd0, res_valid}, {31'd0, m_rv});
        chk("busy", {31'd0, busy}, (m_q.size() > 0) ? 32'd1 : 32'd0);
        chk("op_count", {16'd0, op_count}, 32'(m_count));
        if (m_rv) begin
            chk("res_data", {24'd0, res_data}, {24'd0, m_q[0].d});
            chk("res_id", {30'd0, res_id}, 32'(m_q[0].id));
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    function automatic logic [31:0] rnd32();
        return $urandom();
    endfunction

    // Saturating counter instance: compare op_count against completions seen so far.
    always @(posedge clk) begin
        if (rst2_n && res_valid2) n2 <= n2 + 1;
    end
    always @(negedge clk) begin
        if (rst2_n && n2 <= 20) chk("sat_count", {28'd0, op_count2}, (n2 > 15) ? 32'd15 : 32'(n2));
    end

    typedef struct {
        logic [3:0] v;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_d;
        logic [1:0] exp_id;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int          ids[$];
        int          ks[$];
        logic [7:0]  hd;
        logic [1:0]  hid;
        logic [15:0] c0;
        int          seen3;
        int          got1;
        logic [31:0] a;
        logic [31:0] b;

        tbl[0] = '{4'b0100, 8'hF0, 8'h3C, 8'hCF, 2'd2};
        tbl[1] = '{4'b0001, 8'hFF, 8'hFF, 8'h00, 2'd0};
        tbl[2] = '{4'b0010, 8'h00, 8'h00, 8'hFF, 2'd1};
        tbl[3] = '{4'b1000, 8'hAA, 8'h55, 8'hFF, 2'd3};
        tbl[4] = '{4'b0001, 8'h0F, 8'hFF, 8'hF0, 2'd0};
        tbl[5] = '{4'b1000, 8'hC3, 8'h81, 8'h7E, 2'd3};

        // Reset with all requesters valid: nothing may be granted.
        rst_n = 1'b0; rst2_n = 1'b0;
        req_valid = 4'b1111; req_a = 32'h0; req_b = 32'h0; ena = 1'b1; res_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_op_count", {16'd0, op_count}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; rst2_n = 1'b1;

        // All four valid, res_ready high: grants 0,1,2,3,0 every third cycle.
        for (int k = 0; k < 15; k++) begin
            step(4'b1111, rnd32(), rnd32(), 1'b1, 1'b1);
            if (s_ready != 4'b0000) begin
                chk("order_onehot", {31'd0, $onehot(s_ready)}, 32'd1);
                for (int j = 0; j < 4; j++) if (s_ready[j]) ids.push_back(j);
                ks.push_back(k);
            end
        end
        chk("order_n", 32'(ids.size()), 32'd5);
        for (int i = 0; i < ids.size() && i < 5; i++) begin
            chk("order_id", 32'(ids[i]), 32'(i % 4));
            chk("order_gap", 32'(ks[i]), 32'(3 * i));
        end

        // Vector table: single requester, operands changed after the grant edge.
        for (int i = 0; i < 6; i++) begin
            a = rnd32(); b = rnd32();
            a[tbl[i].exp_id*8 +: 8] = tbl[i].a;
            b[tbl[i].exp_id*8 +: 8] = tbl[i].b;
            c0 = op_count;
            step(tbl[i].v, a, b, 1'b1, 1'b1);
            chk("tbl_ready", {28'd0, s_ready}, {28'd0, tbl[i].v});
            step(4'b0000, rnd32(), rnd32(), 1'b1, 1'b1);
            step(4'b0000, rnd32(), rnd32(), 1'b1, 1'b1);
            chk("tbl_valid", {31'd0, s_rv}, 32'd1);
            chk("tbl_data", {24'd0, s_data}, {24'd0, tbl[i].exp_d});
            chk("tbl_id", {30'd0, s_id}, {30'd0, tbl[i].exp_id});
            step(4'b0000, rnd32(), rnd32(), 1'b1, 1'b1);
            chk("tbl_count", {16'd0, op_count}, 32'(c0) + 32'd1);
        end

        // Backpressure: result held for 5 cycles, no grant while waiting.
        step(4'b0001, rnd32(), rnd32(), 1'b1, 1'b0);
        step(4'b0000, rnd32(), rnd32(), 1'b1, 1'b0);
        step(4'b1111, rnd32(), rnd32(), 1'b1, 1'b0);
        hd = s_data; hid = s_id;
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, rnd32(), rnd32(), 1'b1, 1'b0);
            chk("bp_valid", {31'd0, s_rv}, 32'd1);
            chk("bp_data", {24'd0, s_data}, {24'd0, hd});
            chk("bp_id", {30'd0, s_id}, {30'd0, hid});
            chk("bp_ready", {28'd0, s_ready}, 32'd0);
        end
        step(4'b1111, rnd32(), rnd32(), 1'b1, 1'b1);
        c0 = s_cnt;
        chk("bp_hs_ready", {28'd0, s_ready}, 32'd0);
        step(4'b0000, rnd32(), rnd32(), 1'b1, 1'b0);
        chk("bp_drop", {31'd0, s_rv}, 32'd0);
        chk("bp_count", {16'd0, s_cnt}, 32'(c0) + 32'd1);

        // ena dropped during EXEC: req1 completes, req3 waits for ena.
        step(4'b0010, rnd32(), rnd32(), 1'b1, 1'b1);
        chk("ena_grant1", {28'd0, s_ready}, 32'd2);
        seen3 = 0; got1 = 0;
        for (int k = 0; k < 5; k++) begin
            step(4'b1000, rnd32(), rnd32(), 1'b0, 1'b1);
            if (s_ready[3]) seen3++;
            if (s_rv && s_id == 2'd1) got1++;
        end
        chk("ena_no_grant3", 32'(seen3), 32'd0);
        chk("ena_result1", 32'(got1), 32'd1);
        step(4'b1000, rnd32(), rnd32(), 1'b1, 1'b1);
        chk("ena_grant3", {28'd0, s_ready}, 32'd8);

        // Random traffic against the model.
        for (int k = 0; k < 300; k++) begin
            step(4'($urandom_range(0, 15)), rnd32(), rnd32(),
                 ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
        end

        // Drain, then reset asynchronously in the middle of HOLD.
        for (int k = 0; k < 4; k++) step(4'b0000, rnd32(), rnd32(), 1'b1, 1'b1);
        step(4'b0100, rnd32(), rnd32(), 1'b1, 1'b0);
        step(4'b0000, rnd32(), rnd32(), 1'b1, 1'b0);
        step(4'b0000, rnd32(), rnd32(), 1'b1, 1'b0);
        chk("hold_valid", {31'd0, s_rv}, 32'd1);
        req_valid = 4'b1111; ena = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, res_valid}, 32'd0);
        chk("arst_data", {24'd0, res_data}, 32'd0);
        chk("arst_id", {30'd0, res_id}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_count", {16'd0, op_count}, 32'd0);
        chk("arst_ready", {28'd0, req_ready}, 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(4'b1111, rnd32(), rnd32(), 1'b1, 1'b1);
        chk("arst_first", {28'd0, s_ready}, 32'd1);
        for (int k = 0; k < 4; k++) step(4'b0000, rnd32(), rnd32(), 1'b1, 1'b1);

        chk("sat_ops", (n2 >= 17) ? 32'd1 : 32'd0, 32'd1);
        chk("sat_final", {28'd0, op_count2}, 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
